// File: rtl/ram_port_arbiter_if.sv
// Requester A/B handshake ports and RAM-side bus of ram_port_arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface ram_port_arbiter_if #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_SIZE  = 896
);
  localparam int AW = $clog2(MEM_SIZE);

  logic                 a_valid, a_ready, a_we, a_lock, a_rvalid;
  logic [AW-1:0]        a_addr;
  logic [MEM_WIDTH-1:0] a_di, a_rdata;

  logic                 b_valid, b_ready, b_we, b_lock, b_rvalid;
  logic [AW-1:0]        b_addr;
  logic [MEM_WIDTH-1:0] b_di, b_rdata;

  logic                 ram_en, ram_we;
  logic [AW-1:0]        ram_addr;
  logic [MEM_WIDTH-1:0] ram_di, ram_dout;

  modport slave (
    input  a_valid, a_we, a_addr, a_di, a_lock,
    output a_ready, a_rdata, a_rvalid,
    input  b_valid, b_we, b_addr, b_di, b_lock,
    output b_ready, b_rdata, b_rvalid,
    output ram_en, ram_we, ram_addr, ram_di,
    input  ram_dout
  );

  modport master (
    output a_valid, a_we, a_addr, a_di, a_lock,
    input  a_ready, a_rdata, a_rvalid,
    output b_valid, b_we, b_addr, b_di, b_lock,
    input  b_ready, b_rdata, b_rvalid,
    input  ram_en, ram_we, ram_addr, ram_di,
    output ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with bounded
// bus lock and read-data routing back to the issuing requester.
module ram_port_arbiter #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_SIZE  = 896,
  parameter int MAX_LOCK  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus
);
  localparam int AW  = $clog2(MEM_SIZE);
  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [LCW-1:0]       lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_owner_q, rd_owner_d;
  logic                 a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [MEM_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic                 grant_a, grant_b, xfer;
  logic                 g_we, g_lock, owner_lock;
  logic [AW-1:0]        addr_sel;
  logic [MEM_WIDTH-1:0] di_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Grant uses only valids and registered state, so ready never feeds back into itself.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == LOCKED) begin
      grant_a = !owner_q && bus.a_valid;
      grant_b =  owner_q && bus.b_valid;
    end else if (bus.a_valid && bus.b_valid) begin
      grant_a = last_grant_q;
      grant_b = !last_grant_q;
    end else begin
      grant_a = bus.a_valid;
      grant_b = bus.b_valid;
    end
    xfer       = grant_a || grant_b;
    g_we       = grant_b ? bus.b_we   : bus.a_we;
    g_lock     = grant_b ? bus.b_lock : bus.a_lock;
    addr_sel   = grant_b ? bus.b_addr : bus.a_addr;
    di_sel     = grant_b ? bus.b_di   : bus.a_di;
    owner_lock = owner_q ? bus.b_lock : bus.a_lock;
  end

  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.ram_en   = xfer && rst_n;
  assign bus.ram_we   = xfer && g_we && rst_n;
  assign bus.ram_addr = addr_sel;
  assign bus.ram_di   = di_sel;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

  assign lock_cnt_inc = lock_cnt_q + LCW'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = xfer ? grant_b : last_grant_q;
    lock_cnt_d   = lock_cnt_q;

    // Read return: accept -> RAM access -> capture -> rvalid pulse.
    rd_pend_d  = xfer && !g_we;
    rd_owner_d = xfer ? grant_b : rd_owner_q;
    a_rvalid_d = rd_pend_q && !rd_owner_q;
    b_rvalid_d = rd_pend_q &&  rd_owner_q;
    a_rdata_d  = a_rvalid_d ? bus.ram_dout : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? bus.ram_dout : b_rdata_q;

    if (state_q == UNLOCKED) begin
      if (xfer && g_lock && (MAX_LOCK > 1)) begin
        state_d    = LOCKED;
        owner_d    = grant_b;
        lock_cnt_d = LCW'(1);
      end
    end else if (!owner_lock) begin
      state_d    = UNLOCKED;
      lock_cnt_d = '0;
    end else if (lock_cnt_inc == LOCK_MAX) begin
      // Hold budget used up: release and hand the next tie to the other port.
      state_d      = UNLOCKED;
      lock_cnt_d   = '0;
      last_grant_d = owner_q;
    end else begin
      lock_cnt_d = lock_cnt_inc;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM, a reference
// model checked every cycle, and literal per-scenario expectations.
module tb_ram_port_arbiter;
  localparam int MW  = 8;
  localparam int MS  = 896;
  localparam int ML  = 4;
  localparam int AW  = $clog2(MS);

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ram_port_arbiter_if #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) bus();

  ram_port_arbiter #(.MEM_WIDTH(MW), .MEM_SIZE(MS), .MAX_LOCK(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: 1-cycle read latency, dout changes only on reads.
  logic [MW-1:0] ram_mem [MS];
  initial for (int i = 0; i < MS; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_di;
      else            bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain rule evaluation over a memory image and a return queue.
  typedef struct {bit port; logic [MW-1:0] data; int due;} ret_t;
  ret_t          rq[$];
  logic [MW-1:0] ref_mem [MS];
  initial for (int i = 0; i < MS; i++) ref_mem[i] = '0;
  int            cyc = 0;
  bit            m_locked = 0, m_owner = 0, m_last = 1;
  int            m_held = 0;
  logic [MW-1:0] ea_rdata = '0, eb_rdata = '0;

  always @(negedge clk) begin : model
    bit ga, gb, port, we, lk, ev_a, ev_b;
    logic [AW-1:0] ad;
    logic [MW-1:0] di;
    ret_t e;
    cyc++;
    if (!rst_n) begin
      chk("m_rst_ram_en", bus.ram_en, 0);
      chk("m_rst_ram_we", bus.ram_we, 0);
      chk("m_rst_a_rvalid", bus.a_rvalid, 0);
      chk("m_rst_b_rvalid", bus.b_rvalid, 0);
      m_locked = 0; m_owner = 0; m_last = 1; m_held = 0;
      rq.delete();
      ea_rdata = '0; eb_rdata = '0;
    end else begin
      if (m_locked) begin
        ga = (m_owner == 0) && bus.a_valid;
        gb = (m_owner == 1) && bus.b_valid;
      end else if (bus.a_valid && bus.b_valid) begin
        ga = (m_last == 1);
        gb = !ga;
      end else begin
        ga = bus.a_valid;
        gb = bus.b_valid;
      end
      port = gb;
      we = port ? bus.b_we : bus.a_we;
      lk = port ? bus.b_lock : bus.a_lock;
      ad = port ? bus.b_addr : bus.a_addr;
      di = port ? bus.b_di : bus.a_di;
      chk("m_a_ready", bus.a_ready, ga);
      chk("m_b_ready", bus.b_ready, gb);
      chk("m_ram_en", bus.ram_en, ga | gb);
      chk("m_ram_we", bus.ram_we, (ga | gb) & we);
      chk("m_ram_addr", bus.ram_addr, ad);
      if (ga | gb) chk("m_ram_di", bus.ram_di, di);

      ev_a = 0; ev_b = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        if (e.port) begin ev_b = 1; eb_rdata = e.data; end
        else        begin ev_a = 1; ea_rdata = e.data; end
      end
      chk("m_a_rvalid", bus.a_rvalid, ev_a);
      chk("m_b_rvalid", bus.b_rvalid, ev_b);
      chk("m_a_rdata", bus.a_rdata, ea_rdata);
      chk("m_b_rdata", bus.b_rdata, eb_rdata);

      if (ga | gb) begin
        if (we) ref_mem[ad] = di;
        else    rq.push_back('{port, ref_mem[ad], cyc + 2});
        m_last = port;
      end
      if (m_locked) begin
        if (!(m_owner ? bus.b_lock : bus.a_lock)) begin
          m_locked = 0; m_held = 0;
        end else begin
          m_held++;
          if (m_held >= ML) begin m_locked = 0; m_held = 0; m_last = m_owner; end
        end
      end else if ((ga | gb) && lk) begin
        m_locked = 1; m_owner = port; m_held = 1;
        if (m_held >= ML) begin m_locked = 0; m_held = 0; end
      end
    end
  end

  task automatic drive(input logic av, input logic awe, input logic [AW-1:0] aad,
                       input logic [MW-1:0] adi, input logic alk,
                       input logic bv, input logic bwe, input logic [AW-1:0] bad,
                       input logic [MW-1:0] bdi, input logic blk);
    @(posedge clk);
    #1;
    bus.a_valid = av; bus.a_we = awe; bus.a_addr = aad; bus.a_di = adi; bus.a_lock = alk;
    bus.b_valid = bv; bus.b_we = bwe; bus.b_addr = bad; bus.b_di = bdi; bus.b_lock = blk;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.a_valid = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_di = '0; bus.a_lock = 0;
    bus.b_valid = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_di = '0; bus.b_lock = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: lone write then read back
    drive(1, 1, 3, 8'h5A, 0, 0, 0, 0, 0, 0);
    chk("t1_a_ready", bus.a_ready, 1);
    chk("t1_ram_en", bus.ram_en, 1);
    chk("t1_ram_we", bus.ram_we, 1);
    chk("t1_ram_addr", bus.ram_addr, 3);
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_rd_ready", bus.a_ready, 1);
    chk("t1_rd_we", bus.ram_we, 0);
    idle();
    chk("t1_early_rvalid", bus.a_rvalid, 0);
    idle();
    chk("t1_a_rvalid", bus.a_rvalid, 1);
    chk("t1_a_rdata", bus.a_rdata, 8'h5A);
    chk("t1_b_rvalid", bus.b_rvalid, 0);

    // 2: alternating reads under contention
    drive(1, 1, 10, 8'hA1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 20, 8'hB2, 0);
    drive(1, 0, 10, 0, 0, 1, 0, 20, 0, 0);
    chk("t2_c0_a", bus.a_ready, 1); chk("t2_c0_b", bus.b_ready, 0);
    drive(1, 0, 10, 0, 0, 1, 0, 20, 0, 0);
    chk("t2_c1_a", bus.a_ready, 0); chk("t2_c1_b", bus.b_ready, 1);
    drive(1, 0, 10, 0, 0, 1, 0, 20, 0, 0);
    chk("t2_c2_a", bus.a_ready, 1);
    chk("t2_c2_arv", bus.a_rvalid, 1); chk("t2_c2_ard", bus.a_rdata, 8'hA1);
    drive(1, 0, 10, 0, 0, 1, 0, 20, 0, 0);
    chk("t2_c3_b", bus.b_ready, 1);
    chk("t2_c3_brv", bus.b_rvalid, 1); chk("t2_c3_brd", bus.b_rdata, 8'hB2);
    idle();
    chk("t2_c4_arv", bus.a_rvalid, 1); chk("t2_c4_ard", bus.a_rdata, 8'hA1);
    idle();
    chk("t2_c5_brv", bus.b_rvalid, 1); chk("t2_c5_brd", bus.b_rdata, 8'hB2);

    // 3: locked burst of writes, B shut out until the lock drops
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, AW'(k), MW'(8'h30 + k), (k < 3), 1, 0, 20, 0, 0);
      chk("t3_a_ready", bus.a_ready, 1);
      chk("t3_b_ready", bus.b_ready, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 20, 0, 0);
    chk("t3_b_after", bus.b_ready, 1);
    idle();
    idle();
    chk("t3_brv", bus.b_rvalid, 1); chk("t3_brd", bus.b_rdata, 8'hB2);

    // 4: lock timeout after ML transfers, then re-acquire and idle-hold
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, AW'(40 + k), MW'(k), 1, 1, 0, 20, 0, 0);
      chk("t4_a_ready", bus.a_ready, 1);
      chk("t4_b_ready", bus.b_ready, 0);
    end
    drive(1, 1, 44, 4, 1, 1, 0, 20, 0, 0);
    chk("t4_to_a", bus.a_ready, 0); chk("t4_to_b", bus.b_ready, 1);
    drive(1, 1, 45, 5, 1, 0, 0, 0, 0, 0);
    chk("t4_reacq_a", bus.a_ready, 1);
    drive(0, 0, 0, 0, 1, 1, 0, 20, 0, 0);
    chk("t4_hold_b", bus.b_ready, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 20, 0, 0);
    chk("t4_drop_b", bus.b_ready, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 20, 0, 0);
    chk("t4_free_b", bus.b_ready, 1);
    idle();
    idle();

    // 5: reset with a read in flight
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_a_ready", bus.a_ready, 1);
    @(posedge clk); #1 rst_n = 1'b0; #1;
    chk("t5_rst_en", bus.ram_en, 0);
    chk("t5_rst_we", bus.ram_we, 0);
    @(posedge clk); #2;
    chk("t5_rst_en2", bus.ram_en, 0);
    chk("t5_rst_arv", bus.a_rvalid, 0);
    @(posedge clk); #1 rst_n = 1'b1; bus.a_valid = 0; #1;
    chk("t5_post_arv", bus.a_rvalid, 0);
    drive(1, 0, 3, 0, 0, 1, 0, 20, 0, 0);
    chk("t5_tie_a", bus.a_ready, 1); chk("t5_tie_b", bus.b_ready, 0);
    idle();
    chk("t5_arv_early", bus.a_rvalid, 0);
    idle();
    chk("t5_arv", bus.a_rvalid, 1); chk("t5_ard", bus.a_rdata, 8'h33);

    // 6: read, foreign write, read again
    drive(1, 1, 7, 8'h11, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 7, 8'h22, 0);
    chk("t6_b_ready", bus.b_ready, 1);
    drive(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_arv1", bus.a_rvalid, 1); chk("t6_ard1", bus.a_rdata, 8'h11);
    idle();
    chk("t6_arv_gap", bus.a_rvalid, 0);
    chk("t6_brv_wr", bus.b_rvalid, 0);
    chk("t6_ard_hold", bus.a_rdata, 8'h11);
    idle();
    chk("t6_arv2", bus.a_rvalid, 1); chk("t6_ard2", bus.a_rdata, 8'h22);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single_port_ram instance (1-cycle read latency, registered dout updated only on reads) between two requesters, e.g. the NTT engine (port A) and the sampler/encoder (port B).
- Per-access valid/ready handshake, round-robin arbitration, an optional bus lock for bursts with a bounded hold time, and routing of read data back to the issuing requester.
- Sits directly in front of the RAM; the RAM's en/we/addr/di are driven only by this block.

Parameters:
MEM_WIDTH, 8, data width; must match the RAM.
MEM_SIZE, 896, RAM depth; address width AW = $clog2(MEM_SIZE).
MAX_LOCK, 64, maximum consecutive cycles one requester may hold the lock (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
a_valid  in  1  port A access request.
a_ready  out  1  port A access accepted this cycle.
a_we  in  1  port A: 1 = write, 0 = read.
a_addr  in  AW  port A address.
a_di  in  MEM_WIDTH  port A write data.
a_lock  in  1  port A requests to keep ownership after this access.
a_rdata  out  MEM_WIDTH  port A read data.
a_rvalid  out  1  port A read data valid, 1-cycle pulse.
b_valid, b_ready, b_we, b_addr, b_di, b_lock, b_rdata, b_rvalid: as port A, for port B.
ram_en  out  1  RAM enable.
ram_we  out  1  RAM write enable.
ram_addr  out  AW  RAM address.
ram_di  out  MEM_WIDTH  RAM write data.
ram_dout  in  MEM_WIDTH  RAM registered read data.

Behaviour:
- Registered state:
  - last_grant: 0 = A, 1 = B; reset 1, so A wins the first tie.
  - owner: 0 = A, 1 = B.
  - locked: reset 0.
  - lock_cnt: width $clog2(MAX_LOCK+1); reset 0.
  - rd_pend: reset 0.
  - rd_owner: reset 0.
  - a_rvalid / b_rvalid: reset 0.
  - a_rdata / b_rdata: reset 0.
- States: UNLOCKED (locked = 0) and LOCKED (locked = 1, owner fixed).
- Grant selection, combinational, same cycle:
  - LOCKED: only the owner can be granted, and only if its valid is high. The other port's ready is 0.
  - UNLOCKED, exactly one valid: that port is granted.
  - UNLOCKED, both valid: the port != last_grant is granted.
  - Neither valid: no grant.
- Handshake:
  - x_ready = 1 iff port x is granted. A transfer occurs when valid & ready.
  - Ready depends only on valid and registered state, never on ready, so there is no combinational loop.
- RAM drive on a transfer:
  - ram_en = 1.
  - ram_we, ram_addr, ram_di are taken from the granted port.
  - With no transfer, ram_en = 0, ram_we = 0, and addr/di hold the port A values.
  - ram_en = 0 and ram_we = 0 whenever rst_n = 0.
- Read return:
  - A read transfer in cycle N sets rd_pend and rd_owner.
  - In cycle N+1, rd_pend causes ram_dout to be captured into rd_owner's rdata register. That port's rvalid is 1 in cycle N+2, for exactly one cycle.
  - Total latency: 2 cycles from accept to rvalid.
  - Back-to-back reads return in order, one per cycle.
  - rdata holds its value between pulses.
  - Writes produce no rvalid.
- last_grant updates to the granted port on every transfer.
- Lock rules (evaluated at the clock edge):
  - UNLOCKED -> LOCKED: on a transfer with the granted port's lock = 1. Set owner = granted port, lock_cnt = 1.
  - LOCKED, idle cycle: if owner's lock = 1, stay LOCKED and increment lock_cnt, even when the owner's valid = 0.
  - LOCKED -> UNLOCKED: the cycle after any cycle where owner's lock = 0 (with or without a transfer); clear lock_cnt.
  - Timeout: if lock_cnt == MAX_LOCK at the edge, force UNLOCKED and set last_grant = owner, so the other port wins the next tie. The owner may re-lock via a fresh locked transfer once it is granted again.
  - lock_cnt saturates at MAX_LOCK and never wraps.
- Reset mid-operation: all registered state returns to reset values asynchronously. Any in-flight read is dropped with no rvalid. Requesters must reissue.
- Address range is not checked. Callers guarantee addr < MEM_SIZE.

Test Plan:
1. Reset, then A writes 0x5A to addr 3 alone -> a_ready = 1 same cycle, ram_en = 1, ram_we = 1, ram_addr = 3. A then reads addr 3 -> a_rvalid pulses 2 cycles later with a_rdata = 0x5A, and b_rvalid stays 0.
2. A and B both hold valid reads (addr 10, 20) for 4 cycles, no lock -> grants A, B, A, B. Returns alternate a_rvalid/b_rvalid with the correct data each cycle.
3. A asserts lock with writes at 0..3 while B holds valid -> b_ready = 0 throughout. A drops lock on the 4th access -> B is granted the following cycle.
4. MAX_LOCK = 4: A holds lock and valid continuously with B valid -> A gets 4 transfers, then B is granted, then A re-acquires.
5. A issues a read, and rst_n is pulsed low in the next cycle -> no rvalid afterwards, ram_en = 0 during reset, and the first tie after reset goes to A.
6. A reads addr 7 (data 0x11), then B writes addr 7 = 0x22, then A reads addr 7 -> a_rdata = 0x11, then 0x22, and no rvalid is produced for the write.
